// File: rtl/synchronous_fifo.sv
// synchronous_fifo: single-clock circular-buffer FIFO with registered read
// data and full/empty flags decoded from an occupancy counter.
module synchronous_fifo #(
  parameter  int DATA_WIDTH = 8,
  parameter  int DEPTH      = 16,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,      // active-high asynchronous reset
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  wr_en,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty
);

  localparam logic [ADDR_WIDTH:0]   L_DEPTH   = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] L_PTR_ONE = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   L_CNT_ONE = (ADDR_WIDTH + 1)'(1);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic [DATA_WIDTH-1:0] r_data_out;

  logic w_full;
  logic w_empty;
  logic w_wr_accept;
  logic w_rd_accept;

  // Flags decode straight from the counter; a write while full is refused
  // even when a read is accepted on the same edge.
  always_comb begin
    w_full      = (r_count == L_DEPTH);
    w_empty     = (r_count == '0);
    w_wr_accept = wr_en & ~w_full;
    w_rd_accept = rd_en & ~w_empty;
  end

  // Storage write; memory is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (w_wr_accept) begin
      r_mem[r_wr_ptr] <= data_in;
    end
  end

  // Pointers advance on accepted transfers and wrap naturally at DEPTH.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_accept) r_wr_ptr <= r_wr_ptr + L_PTR_ONE;
      if (w_rd_accept) r_rd_ptr <= r_rd_ptr + L_PTR_ONE;
    end
  end

  // Occupancy counter: unchanged when both sides transfer together.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_count <= '0;
    end else begin
      case ({w_wr_accept, w_rd_accept})
        2'b10:   r_count <= r_count + L_CNT_ONE;
        2'b01:   r_count <= r_count - L_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Registered read data; holds its value when no read is accepted.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_data_out <= '0;
    end else if (w_rd_accept) begin
      r_data_out <= r_mem[r_rd_ptr];
    end
  end

  assign data_out = r_data_out;
  assign full     = w_full;
  assign empty    = w_empty;

endmodule

// File: tb/tb_synchronous_fifo.sv
// Directed self-checking bench for synchronous_fifo (DEPTH=16, 8-bit data).
module tb_synchronous_fifo;

  logic       clk;
  logic       rst_n;
  logic [7:0] data_in;
  logic       wr_en;
  logic       rd_en;
  logic [7:0] data_out;
  logic       full;
  logic       empty;

  int unsigned total = 0;
  int unsigned bad   = 0;

  synchronous_fifo #(.DATA_WIDTH(8), .DEPTH(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .data_in  (data_in),
    .wr_en    (wr_en),
    .rd_en    (rd_en),
    .data_out (data_out),
    .full     (full),
    .empty    (empty)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    bad = bad + 1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    if (obs !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] exp_q [$];

  initial begin
    rst_n   = 1'b1;
    data_in = '0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;

    // Reset held across the first edge, released 1 ns after it.
    @(posedge clk);
    #1;
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_dout", 32'(data_out), 32'h00);
    rst_n = 1'b0;
    tick();
    check("idle_empty", 32'(empty), 32'd1);

    // Fill 0x00..0x0F.
    for (int i = 0; i < 16; i++) begin
      data_in = 8'(i);
      wr_en   = 1'b1;
      tick();
      check("fill_full", 32'(full), (i == 15) ? 32'd1 : 32'd0);
      check("fill_empty", 32'(empty), 32'd0);
    end
    wr_en = 1'b0;

    // Overflow write is ignored.
    data_in = 8'hAA;
    wr_en   = 1'b1;
    tick();
    wr_en = 1'b0;
    check("ovf_full", 32'(full), 32'd1);

    // Drain in order; 0xAA never appears.
    for (int i = 0; i < 16; i++) begin
      rd_en = 1'b1;
      tick();
      check("drain_dout", 32'(data_out), 32'(i));
      check("drain_empty", 32'(empty), (i == 15) ? 32'd1 : 32'd0);
      check("drain_full", 32'(full), 32'd0);
    end
    rd_en = 1'b0;

    // Underflow read holds data_out.
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("udf_dout", 32'(data_out), 32'h0F);
    check("udf_empty", 32'(empty), 32'd1);

    // Simultaneous read/write while empty: write only.
    data_in = 8'h55;
    wr_en   = 1'b1;
    rd_en   = 1'b1;
    tick();
    rd_en = 1'b0;
    check("bothempty_empty", 32'(empty), 32'd0);
    check("bothempty_dout", 32'(data_out), 32'h0F);
    exp_q.push_back(8'h55);

    // Top up to 8 stored words.
    for (int i = 0; i < 7; i++) begin
      data_in = 8'h60 + 8'(i);
      tick();
      exp_q.push_back(8'h60 + 8'(i));
    end

    // 20 cycles of simultaneous read/write at half full; pointers wrap.
    rd_en = 1'b1;
    for (int k = 0; k < 20; k++) begin
      data_in = 8'h80 + 8'(k);
      exp_q.push_back(8'h80 + 8'(k));
      tick();
      check("half_dout", 32'(data_out), 32'(exp_q.pop_front()));
      check("half_empty", 32'(empty), 32'd0);
      check("half_full", 32'(full), 32'd0);
    end
    wr_en = 1'b0;

    // Exactly 8 words remain: 0x8C..0x93.
    for (int i = 0; i < 8; i++) begin
      tick();
      check("half_drain", 32'(data_out), 32'h8C + 32'(i));
      check("half_drain_empty", 32'(empty), (i == 7) ? 32'd1 : 32'd0);
    end
    rd_en = 1'b0;

    // Fill 0xC0..0xCF, then read+write while full: incoming word dropped.
    wr_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      data_in = 8'hC0 + 8'(i);
      tick();
    end
    check("refill_full", 32'(full), 32'd1);
    data_in = 8'hEE;
    rd_en   = 1'b1;
    tick();
    wr_en = 1'b0;
    check("bothfull_full", 32'(full), 32'd0);
    check("bothfull_dout", 32'(data_out), 32'hC0);
    for (int i = 1; i < 16; i++) begin
      tick();
      check("bothfull_drain", 32'(data_out), 32'hC0 + 32'(i));
    end
    rd_en = 1'b0;
    check("bothfull_empty", 32'(empty), 32'd1);

    // Mid-stream reset with the FIFO full: outputs clear without a clock edge.
    wr_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      data_in = 8'h11 + 8'(i);
      tick();
    end
    wr_en = 1'b0;
    check("pre_rst_full", 32'(full), 32'd1);
    #2;
    rst_n = 1'b1;
    #1;
    check("async_rst_full", 32'(full), 32'd0);
    check("async_rst_empty", 32'(empty), 32'd1);
    check("async_rst_dout", 32'(data_out), 32'h00);
    tick();
    rst_n = 1'b0;

    // Stored data was discarded: next word written is the next word read.
    data_in = 8'h44;
    wr_en   = 1'b1;
    tick();
    wr_en = 1'b0;
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("post_rst_dout", 32'(data_out), 32'h44);
    check("post_rst_empty", 32'(empty), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
